// File: rtl/unidade_load_store.sv
// -----------------------------------------------------------------------------
// unidade_load_store
//   Load/store unit for a word-organised data memory with byte, half and word
//   accesses. Each request is handled one at a time. A byte or half store is a
//   read-modify-write; a word store writes without reading first. Misaligned,
//   illegal-size and out-of-range requests end without touching memory.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req                 start an access (only looked at while idle)
//   i_op_we               1 = store, 0 = load
//   i_size                00 byte, 01 half, 10 word, 11 illegal
//   i_sign_ext            loads: 1 = sign-extend, 0 = zero-extend
//   i_addr, i_wdata       byte address and store data
//   o_busy, o_done        busy while not idle; one-cycle completion pulse
//   o_rdata               last successful load result
//   o_erro_alinhamento    misaligned access or illegal size
//   o_erro_faixa          word index out of range
//   o_mem_addr            word index to memory
//   o_mem_we, o_mem_datain registered memory write strobe and write word
//   i_mem_dataout         memory read word, valid one clock after o_mem_addr
// -----------------------------------------------------------------------------
module unidade_load_store #(
    parameter int MEM_WORDS = 500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_op_we,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_erro_alinhamento,
    output logic        o_erro_faixa,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_datain,
    input  logic [31:0] i_mem_dataout
);

    localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LEITURA = 3'd1,
        CAPTURA = 3'd2,
        ESCRITA = 3'd3,
        FIM     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // latched request
    logic        r_op_we;
    logic [1:0]  r_size;
    logic        r_sign_ext;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;     // only the byte/half lanes are merged later

    logic [31:0] r_rdata;
    logic        r_err_al;
    logic        r_err_fx;
    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [31:0] r_mem_datain;

    logic [31:0] w_idx;
    logic        w_err_al;
    logic        w_err_fx;
    logic        w_accept;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // request decode (combinational on the live inputs, used at the accept edge)
    assign w_idx    = {2'b00, i_addr[31:2]};
    assign w_err_al = (i_size == 2'b11)
                    | ((i_size == 2'b01) & i_addr[0])
                    | ((i_size == 2'b10) & (|i_addr[1:0]));
    assign w_err_fx = (w_idx >= LP_WORDS);
    assign w_accept = (r_state == OCIOSO) & i_req;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= OCIOSO;
        else          r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            OCIOSO: begin
                if (i_req) begin
                    if (w_err_al | w_err_fx)                 w_next = FIM;
                    else if (i_op_we && (i_size == 2'b10))   w_next = ESCRITA;
                    else                                     w_next = LEITURA;
                end
            end
            LEITURA: w_next = CAPTURA;
            CAPTURA: w_next = r_op_we ? ESCRITA : FIM;
            ESCRITA: w_next = FIM;
            FIM:     w_next = OCIOSO;
            default: w_next = OCIOSO;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy = (r_state != OCIOSO);
        o_done = (r_state == FIM);
    end

    // ---------------- lane extraction for loads ----------------
    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0: w_byte = i_mem_dataout[7:0];
            2'd1: w_byte = i_mem_dataout[15:8];
            2'd2: w_byte = i_mem_dataout[23:16];
            2'd3: w_byte = i_mem_dataout[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_off[1] ? i_mem_dataout[31:16] : i_mem_dataout[15:0];

        w_load = i_mem_dataout;
        case (r_size)
            2'b00:   w_load = {{24{r_sign_ext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sign_ext & w_half[15]}}, w_half};
            default: w_load = i_mem_dataout;
        endcase
    end

    // ---------------- lane merge for byte/half stores ----------------
    always_comb begin
        w_merge = i_mem_dataout;
        case (r_size)
            2'b00: begin
                case (r_off)
                    2'd0: w_merge[7:0]   = r_wdata[7:0];
                    2'd1: w_merge[15:8]  = r_wdata[7:0];
                    2'd2: w_merge[23:16] = r_wdata[7:0];
                    2'd3: w_merge[31:24] = r_wdata[7:0];
                    default: w_merge = i_mem_dataout;
                endcase
            end
            2'b01: begin
                if (r_off[1]) w_merge[31:16] = r_wdata;
                else          w_merge[15:0]  = r_wdata;
            end
            default: w_merge = i_mem_dataout;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_we      <= 1'b0;
            r_size       <= 2'b00;
            r_sign_ext   <= 1'b0;
            r_off        <= 2'b00;
            r_wdata      <= 16'h0000;
            r_rdata      <= 32'h0;
            r_err_al     <= 1'b0;
            r_err_fx     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_we     <= 1'b0;
            r_mem_datain <= 32'h0;
        end else begin
            if (w_accept) begin
                r_op_we    <= i_op_we;
                r_size     <= i_size;
                r_sign_ext <= i_sign_ext;
                r_off      <= i_addr[1:0];
                r_wdata    <= i_wdata[15:0];
                r_mem_addr <= w_idx;
                // flags are rewritten on every accepted request, so a clean
                // request clears whatever the previous one left behind
                r_err_al   <= w_err_al;
                r_err_fx   <= w_err_fx;
            end

            // the read word is valid during CAPTURA; loads take it here
            if ((r_state == CAPTURA) && !r_op_we)
                r_rdata <= w_load;

            // strobe is registered from the next state so it is high for
            // exactly the ESCRITA cycle and drops with the async reset
            r_mem_we <= (w_next == ESCRITA);

            // word stores come straight from idle with the raw write data;
            // byte/half stores come from CAPTURA with the merged word
            if (w_next == ESCRITA)
                r_mem_datain <= (r_state == OCIOSO) ? i_wdata : w_merge;
        end
    end

    assign o_rdata            = r_rdata;
    assign o_erro_alinhamento = r_err_al;
    assign o_erro_faixa       = r_err_fx;
    assign o_mem_addr         = r_mem_addr;
    assign o_mem_we           = r_mem_we;
    assign o_mem_datain       = r_mem_datain;

endmodule

// File: tb/tb_unidade_load_store.sv
module tb_unidade_load_store;

    localparam int MW = 500;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        op_we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        erro_al;
    logic        erro_fx;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    unidade_load_store #(.MEM_WORDS(MW)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_req              (req),
        .i_op_we            (op_we),
        .i_size             (size),
        .i_sign_ext         (sign_ext),
        .i_addr             (addr),
        .i_wdata            (wdata),
        .o_busy             (busy),
        .o_done             (done),
        .o_rdata            (rdata),
        .o_erro_alinhamento (erro_al),
        .o_erro_faixa       (erro_fx),
        .o_mem_addr         (mem_addr),
        .o_mem_we           (mem_we),
        .o_mem_datain       (mem_datain),
        .i_mem_dataout      (mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read memory model; the bench preloads words through a port
    logic [31:0] mem [MW];
    logic        tb_wr;
    logic [8:0]  tb_idx;
    logic [31:0] tb_dat;

    always @(posedge clk) begin
        if (tb_wr) mem[tb_idx] <= tb_dat;
        else if (mem_we && (mem_addr < MW)) mem[mem_addr[8:0]] <= mem_datain;
        mem_dataout <= (mem_addr < MW) ? mem[mem_addr[8:0]] : 32'h0;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        ea;
        logic        ef;
        int          lat;
        int          nwe;
        logic [31:0] din;
    } exp_t;

    exp_t sb[$];
    int   exp_done[$];
    int   got_done[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] d);
        @(negedge clk);
        tb_wr  = 1'b1;
        tb_idx = 9'(idx);
        tb_dat = d;
        @(negedge clk);
        tb_wr  = 1'b0;
    endtask

    function automatic void push(input logic [31:0] rd, input logic ea, input logic ef,
                                 input int lat, input int nwe, input logic [31:0] din);
        exp_t e;
        e.rdata = rd; e.ea = ea; e.ef = ef; e.lat = lat; e.nwe = nwe; e.din = din;
        sb.push_back(e);
    endfunction

    // drive one request, watch it to completion and compare against the queue
    task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int lat = 0;
        int nwe = 0;
        logic [31:0] din = 32'h0;
        logic bsy = 1'b0;
        logic ea = 1'b0;
        logic ef = 1'b0;
        @(negedge clk);
        req = 1'b1; op_we = we; size = sz; sign_ext = sx; addr = a; wdata = wd;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (mem_we) begin nwe++; din = mem_datain; end
            if (done) begin lat = c; bsy = busy; ea = erro_al; ef = erro_fx; break; end
        end
        e = sb.pop_front();
        chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
        chk({tag, ".rdata"}, rdata, e.rdata);
        chk({tag, ".erro_al"}, 32'(ea), 32'(e.ea));
        chk({tag, ".erro_fx"}, 32'(ef), 32'(e.ef));
        chk({tag, ".we_pulses"}, 32'(nwe), 32'(e.nwe));
        if (e.nwe > 0) chk({tag, ".datain"}, din, e.din);
        chk({tag, ".busy_at_done"}, 32'(bsy), 32'd1);
        @(negedge clk);
        chk({tag, ".idle_after"}, {30'h0, busy, done}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; op_we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0; tb_wr = 1'b0; tb_idx = 9'h0; tb_dat = 32'h0;
        for (int i = 0; i < MW; i++) mem[i] = 32'h0;

        // reset state before any clock edge
        #3;
        chk("reset.ctrl", {27'h0, busy, done, mem_we, erro_al, erro_fx}, 32'h0);
        chk("reset.rdata", rdata, 32'h0);
        chk("reset.mem_addr", mem_addr, 32'h0);
        chk("reset.datain", mem_datain, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // word load
        poke(4, 32'hDEADBEEF);
        push(32'hDEADBEEF, 1'b0, 1'b0, 3, 0, 32'h0);
        run("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw10.mem_addr", mem_addr, 32'd4);

        // byte/half loads with both extensions
        poke(4, 32'h80FF7F01);
        push(32'hFFFFFF80, 1'b0, 1'b0, 3, 0, 32'h0);
        run("lb13s", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        push(32'h000000FF, 1'b0, 1'b0, 3, 0, 32'h0);
        run("lbu12", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        push(32'hFFFF80FF, 1'b0, 1'b0, 3, 0, 32'h0);
        run("lh12s", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        push(32'h00007F01, 1'b0, 1'b0, 3, 0, 32'h0);
        run("lh10s", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        push(32'h00000001, 1'b0, 1'b0, 3, 0, 32'h0);
        run("lb10s", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);

        // stores: read-modify-write and direct word write
        poke(4, 32'h11223344);
        push(32'h00000001, 1'b0, 1'b0, 4, 1, 32'h1122AA44);
        run("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA);
        chk("sb11.mem4", mem[4], 32'h1122AA44);
        push(32'h00000001, 1'b0, 1'b0, 2, 1, 32'h01020304);
        run("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h01020304);
        chk("sw10.mem4", mem[4], 32'h01020304);
        push(32'h00000001, 1'b0, 1'b0, 4, 1, 32'hBEEF0000);
        run("sh16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234BEEF);

        // error cases: no memory access, rdata untouched
        push(32'h00000001, 1'b1, 1'b0, 1, 0, 32'h0);
        run("lw06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        push(32'h00000001, 1'b0, 1'b1, 1, 0, 32'h0);
        run("lw7d0", 1'b0, 2'b10, 1'b0, 32'h7D0, 32'h0);
        push(32'h00000001, 1'b1, 1'b0, 1, 0, 32'h0);
        run("size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        push(32'h00000001, 1'b1, 1'b1, 1, 0, 32'h0);
        run("sh7d1", 1'b1, 2'b01, 1'b0, 32'h7D1, 32'h5555);
        chk("sh7d1.mem_untouched", mem[4], 32'h01020304);
        // last valid word; flags from the previous request are cleared
        push(32'h00000000, 1'b0, 1'b0, 3, 0, 32'h0);
        run("lw7cc", 1'b0, 2'b10, 1'b0, 32'h7CC, 32'h0);

        // reset during ESCRITA of a half store
        poke(4, 32'h11223344);
        @(negedge clk);
        req = 1'b1; op_we = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h12; wdata = 32'h00005566;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_esc.we_before", 32'(mem_we), 32'd1);
        chk("rst_esc.datain", mem_datain, 32'h55663344);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_esc.ctrl", {27'h0, busy, done, mem_we, erro_al, erro_fx}, 32'h0);
        chk("rst_esc.rdata", rdata, 32'h0);
        chk("rst_esc.datain_clr", mem_datain, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_esc.mem4", mem[4], 32'h11223344);
        push(32'h11223344, 1'b0, 1'b0, 3, 0, 32'h0);
        run("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // req held high: one access at a time, each new one starts from idle
        poke(4, 32'hCAFEF00D);
        exp_done.push_back(3);
        exp_done.push_back(7);
        exp_done.push_back(11);
        @(negedge clk);
        req = 1'b1; op_we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 9) req = 1'b0;
            if (done) got_done.push_back(c);
            if (c == 4) chk("held.idle_gap", 32'(busy), 32'd0);
        end
        chk("held.count", 32'(got_done.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            int g;
            g = (i < got_done.size()) ? got_done[i] : 0;
            chk($sformatf("held.done%0d", i), 32'(g), 32'(exp_done[i]));
        end
        chk("held.rdata", rdata, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
